// File: rtl/core_boot_ctrl.sv
// Boot/run sequencer: streams a program image into memory, holds the core in reset,
// then runs it free-running or single-step, with halt and reload support.
module core_boot_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int HOLD_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              img_valid,
  input  logic [DATA_W-1:0] img_data,
  input  logic              img_last,
  output logic              img_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              core_reset,
  output logic              core_clk_en,
  input  logic              step_mode,
  input  logic              step_req,
  input  logic              halt_req,
  input  logic              reload_req,
  output logic [2:0]        state,
  output logic [ADDR_W:0]   words_loaded,
  output logic              ovf_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HOLD = 3'd2,
    S_RUN  = 3'd3,
    S_STEP = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam int HCW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD_CYC - 1);
  localparam logic [ADDR_W:0] DEPTH_M1  = (ADDR_W+1)'((1 << ADDR_W) - 1);

  state_t              state_q, state_d;
  logic [HCW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic                ovf_q, ovf_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                core_reset_q, core_reset_d;
  logic                clk_en_q, clk_en_d;
  logic                step_q;
  logic                step_rise, hs;

  assign img_ready    = (state_q == S_LOAD) && !reset;
  assign hs           = img_valid && img_ready;
  assign step_rise    = step_req && !step_q;
  assign state        = state_q;
  assign words_loaded = words_q;
  assign ovf_err      = ovf_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign core_reset   = core_reset_q;
  assign core_clk_en  = clk_en_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hold_cnt_q   <= '0;
      words_q      <= '0;
      ovf_q        <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_reset_q <= 1'b1;
      clk_en_q     <= 1'b0;
      step_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      words_q      <= words_d;
      ovf_q        <= ovf_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_reset_q <= core_reset_d;
      clk_en_q     <= clk_en_d;
      step_q       <= step_req;
    end
  end

  // Outputs are registered, so each branch computes the value seen in the next state.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    words_d      = words_q;
    ovf_d        = ovf_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_reset_d = core_reset_q;
    clk_en_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d      = S_LOAD;
        core_reset_d = 1'b1;
      end
      S_LOAD: begin
        core_reset_d = 1'b1;
        if (hs) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = words_q[ADDR_W-1:0];
          mem_wdata_d = img_data;
          words_d     = words_q + 1'b1;
          // Full depth without a last marker means the image overflowed memory.
          if (img_last || (words_q == DEPTH_M1)) begin
            state_d    = S_HOLD;
            hold_cnt_d = '0;
            if (!img_last) ovf_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          core_reset_d = 1'b0;
          state_d      = step_mode ? S_STEP : S_RUN;
          clk_en_d     = !step_mode;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (halt_req)       state_d = S_HALT;
        else if (step_mode) state_d = S_STEP;
        else                clk_en_d = 1'b1;
      end
      S_STEP: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (!step_mode) begin
          state_d  = S_RUN;
          clk_en_d = 1'b1;
        end else begin
          clk_en_d = step_rise;
        end
      end
      S_HALT: begin
        if (reload_req) begin
          state_d      = S_LOAD;
          words_d      = '0;
          ovf_d        = 1'b0;
          core_reset_d = 1'b1;
        end else if (!halt_req) begin
          state_d  = step_mode ? S_STEP : S_RUN;
          clk_en_d = !step_mode;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
